hs32_opfetch: RTL and testbench

- Operand-fetch stage between instruction decode and execute.
- Accepts one decoded instruction at a time over a valid/ready handshake and drives the register file read ports. It captures both operands, substitutes an immediate when requested, and presents a complete operand bundle to execute over valid/ready.
- Also owns the register-file write port. Execute writebacks have priority over reads, with a bounded-starvation limit.

---
 rtl/hs32_opfetch.sv | 129 ++++++++++++
 tb/tb_hs32_opfetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_opfetch.sv
// Operand-fetch stage: takes one decoded instruction, reads both source operands
// from the register file (or substitutes an immediate) and hands a bundle to execute.
module hs32_opfetch #(
   parameter int OP_W        = 8,
   parameter int STALL_LIMIT = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [OP_W-1:0] dec_op,
   input  logic [3:0]      dec_rd,
   input  logic [3:0]      dec_rm,
   input  logic [3:0]      dec_rn,
   input  logic            dec_use_imm,
   input  logic [31:0]     dec_imm,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic [3:0]      wb_adr,
   input  logic [31:0]     wb_data,
   output logic            rf_we,
   output logic [3:0]      rf_wadr,
   output logic [31:0]     rf_din,
   output logic [3:0]      rf_radr1,
   output logic [3:0]      rf_radr2,
   input  logic [31:0]     rf_dout1,
   input  logic [31:0]     rf_dout2,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [OP_W-1:0] ex_op,
   output logic [3:0]      ex_rd,
   output logic [31:0]     ex_a,
   output logic [31:0]     ex_b
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int SC_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
   localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_LIMIT);

   state_t            state;
   logic [SC_W-1:0]   stall_cnt;
   logic [OP_W-1:0]   op_q;
   logic [3:0]        rd_q;
   logic [3:0]        rm_q;
   logic [3:0]        rn_q;
   logic              use_imm_q;
   logic [31:0]       imm_q;
   logic              accept;
   logic              starved;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // A producer holds valid and its payload until that edge; ready may depend on state
   // and on the consumer's ready, never on the producer's valid.
   assign dec_ready = (state == IDLE) | ((state == OUT) & ex_ready);
   assign accept    = dec_valid & dec_ready;

   // After STALL_LIMIT lost reads, refuse one writeback so the read can land.
   assign starved   = (state == READ) && (stall_cnt == STALL_MAX);
   assign wb_ready  = !reset && !starved;
   assign rf_we     = wb_valid & wb_ready;
   assign rf_wadr   = wb_adr;
   assign rf_din    = wb_data;

   assign rf_radr1  = rm_q;
   assign rf_radr2  = rn_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         stall_cnt <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         rm_q      <= '0;
         rn_q      <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         ex_valid  <= 1'b0;
         ex_op     <= '0;
         ex_rd     <= '0;
         ex_a      <= '0;
         ex_b      <= '0;
      end else begin
         if (accept) begin
            op_q      <= dec_op;
            rd_q      <= dec_rd;
            rm_q      <= dec_rm;
            rn_q      <= dec_rn;
            use_imm_q <= dec_use_imm;
            imm_q     <= dec_imm;
         end

         unique case (state)
            IDLE: begin
               if (accept) state <= READ;
            end
            READ: begin
               // A write on this cycle's falling edge blocks the read data update,
               // so the read is retried and sees the freshly written value.
               if (rf_we) begin
                  stall_cnt <= stall_cnt + SC_W'(1);
               end else begin
                  ex_a      <= rf_dout1;
                  ex_b      <= use_imm_q ? imm_q : rf_dout2;
                  ex_op     <= op_q;
                  ex_rd     <= rd_q;
                  ex_valid  <= 1'b1;
                  stall_cnt <= '0;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (ex_ready) begin
                  ex_valid <= 1'b0;
                  state    <= accept ? READ : IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_opfetch.sv
// Directed bench for hs32_opfetch with a behavioural register file that honours the
// falling-edge write/read contract.
module tb_hs32_opfetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   logic [7:0]  dec_op;
   logic [3:0]  dec_rd;
   logic [3:0]  dec_rm;
   logic [3:0]  dec_rn;
   logic        dec_use_imm;
   logic [31:0] dec_imm;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_adr;
   logic [31:0] wb_data;
   logic        rf_we;
   logic [3:0]  rf_wadr;
   logic [31:0] rf_din;
   logic [3:0]  rf_radr1;
   logic [3:0]  rf_radr2;
   logic [31:0] rf_dout1;
   logic [31:0] rf_dout2;
   logic        ex_valid;
   logic        ex_ready;
   logic [7:0]  ex_op;
   logic [3:0]  ex_rd;
   logic [31:0] ex_a;
   logic [31:0] ex_b;

   int checks = 0;
   int errors = 0;
   logic [67:0] exp_q[$];

   hs32_opfetch #(.OP_W(8), .STALL_LIMIT(3)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
      .dec_rm(dec_rm), .dec_rn(dec_rn), .dec_use_imm(dec_use_imm), .dec_imm(dec_imm),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_adr(wb_adr), .wb_data(wb_data),
      .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din),
      .rf_radr1(rf_radr1), .rf_radr2(rf_radr2), .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
      .ex_a(ex_a), .ex_b(ex_b)
   );

   // ---------------- clock / register file model ----------------
   always #5 clk = ~clk;

   logic [31:0] mem [16];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      rf_dout1 = 32'h0;
      rf_dout2 = 32'h0;
   end

   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         mem[rf_wadr] <= rf_din;
      end else begin
         rf_dout1 <= mem[rf_radr1];
         rf_dout2 <= mem[rf_radr2];
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst, dv, ui, wv, er;
      logic [7:0]  op;
      logic [3:0]  rd, rm, rn, wa;
      logic [31:0] imm, wd;
      logic        e_dr, e_wr, e_we, e_ev, chk_d, chk_r;
      logic [31:0] e_a, e_b;
      logic [3:0]  e_rd, e_r1, e_r2;
      logic [7:0]  e_op;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(
      input logic [31:0] rst, dv, op, rd, rm, rn, ui, imm, wv, wa, wd, er,
      input logic [31:0] dr, wr, we, ev, cd, a, b, xrd, xop, cr, r1, r2);
      vec_t v;
      v.rst = rst[0];  v.dv = dv[0];   v.op = op[7:0];  v.rd = rd[3:0];
      v.rm = rm[3:0];  v.rn = rn[3:0]; v.ui = ui[0];    v.imm = imm;
      v.wv = wv[0];    v.wa = wa[3:0]; v.wd = wd;       v.er = er[0];
      v.e_dr = dr[0];  v.e_wr = wr[0]; v.e_we = we[0];  v.e_ev = ev[0];
      v.chk_d = cd[0]; v.e_a = a;      v.e_b = b;       v.e_rd = xrd[3:0];
      v.e_op = xop[7:0]; v.chk_r = cr[0]; v.e_r1 = r1[3:0]; v.e_r2 = r2[3:0];
      return v;
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      reset       = v.rst;
      dec_valid   = v.dv;
      dec_op      = v.op;
      dec_rd      = v.rd;
      dec_rm      = v.rm;
      dec_rn      = v.rn;
      dec_use_imm = v.ui;
      dec_imm     = v.imm;
      wb_valid    = v.wv;
      wb_adr      = v.wa;
      wb_data     = v.wd;
      ex_ready    = v.er;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      string s;
      drive(v);
      #2;
      s = $sformatf("[%0d]", k);
      chk({"dec_ready", s}, 32'(dec_ready), 32'(v.e_dr));
      chk({"wb_ready", s},  32'(wb_ready),  32'(v.e_wr));
      chk({"rf_we", s},     32'(rf_we),     32'(v.e_we));
      chk({"ex_valid", s},  32'(ex_valid),  32'(v.e_ev));
      if (v.e_we) begin
         chk({"rf_wadr", s}, 32'(rf_wadr), 32'(v.wa));
         chk({"rf_din", s},  rf_din,       v.wd);
      end
      if (v.chk_d) begin
         chk({"ex_a", s},  ex_a,         v.e_a);
         chk({"ex_b", s},  ex_b,         v.e_b);
         chk({"ex_rd", s}, 32'(ex_rd),   32'(v.e_rd));
         chk({"ex_op", s}, 32'(ex_op),   32'(v.e_op));
      end
      if (v.chk_r) begin
         chk({"rf_radr1", s}, 32'(rf_radr1), 32'(v.e_r1));
         chk({"rf_radr2", s}, 32'(rf_radr2), 32'(v.e_r2));
      end
      tick();
   endtask

   // ---------------- test ----------------
   initial begin
      int lat;
      logic [67:0] exp_b;

      //          rst dv op     rd  rm rn ui imm           wv wa wd            er  dr wr we ev cd a             b             xrd  xop    cr r1 r2
      tbl.push_back(V(1, 0, 0,     0,  0, 0, 0, 0,            1, 1, 32'hDEADDEAD, 0,  1, 0, 0, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 1, 32'h11111111, 0,  1, 1, 1, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 2, 32'h22222222, 0,  1, 1, 1, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 1, 'h5A,  3,  1, 2, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 0, 1, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 1, 1, 32'h11111111, 32'h22222222, 3,   'h5A,  1, 1, 2));
      tbl.push_back(V(0, 1, 'hA5,  4,  1, 2, 1, 32'hDEADBEEF, 0, 0, 0,            1,  1, 1, 0, 1, 1, 32'h11111111, 32'h22222222, 3,   'h5A,  1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 0, 0, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            1,  1, 1, 0, 1, 1, 32'h11111111, 32'hDEADBEEF, 4,   'hA5,  1, 1, 2));
      tbl.push_back(V(0, 1, 'h11,  5,  1, 2, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 0, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 1, 32'hCAFEF00D, 0,  0, 1, 1, 0, 0, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 0, 0, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            1,  1, 1, 0, 1, 1, 32'hCAFEF00D, 32'h22222222, 5,   'h11,  1, 1, 2));
      tbl.push_back(V(0, 1, 'h22,  6,  2, 2, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 0, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 7, 32'h77770000, 0,  0, 1, 1, 0, 0, 0,            0,            0,   0,     1, 2, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 7, 32'h77770000, 0,  0, 1, 1, 0, 0, 0,            0,            0,   0,     1, 2, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 7, 32'h77770000, 0,  0, 1, 1, 0, 0, 0,            0,            0,   0,     1, 2, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 7, 32'h77770000, 0,  0, 0, 0, 0, 0, 0,            0,            0,   0,     1, 2, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            1, 7, 32'h77770000, 0,  0, 1, 1, 1, 1, 32'h22222222, 32'h22222222, 6,   'h22,  1, 2, 2));
      tbl.push_back(V(0, 1, 'h33,  8,  7, 1, 0, 0,            1, 2, 32'h99999999, 0,  0, 1, 1, 1, 1, 32'h22222222, 32'h22222222, 6,   'h22,  1, 2, 2));
      tbl.push_back(V(0, 1, 'h33,  8,  7, 1, 0, 0,            0, 0, 0,            0,  0, 1, 0, 1, 1, 32'h22222222, 32'h22222222, 6,   'h22,  1, 2, 2));
      tbl.push_back(V(0, 1, 'h33,  8,  7, 1, 0, 0,            0, 0, 0,            0,  0, 1, 0, 1, 1, 32'h22222222, 32'h22222222, 6,   'h22,  1, 2, 2));
      tbl.push_back(V(0, 1, 'h33,  8,  7, 1, 0, 0,            0, 0, 0,            1,  1, 1, 0, 1, 1, 32'h22222222, 32'h22222222, 6,   'h22,  1, 2, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 0, 0, 0,            0,            0,   0,     1, 7, 1));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            1,  1, 1, 0, 1, 1, 32'h77770000, 32'hCAFEF00D, 8,   'h33,  1, 7, 1));
      tbl.push_back(V(0, 1, 'h44,  9,  1, 2, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 0, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(1, 0, 0,     0,  0, 0, 0, 0,            1, 1, 32'hBAD0BAD0, 0,  0, 0, 0, 0, 0, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 1, 'h55,  10, 1, 2, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 1, 0,            0,            0,   0,     0, 0, 0));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  0, 1, 0, 0, 0, 0,            0,            0,   0,     1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            1,  1, 1, 0, 1, 1, 32'hCAFEF00D, 32'h99999999, 10,  'h55,  1, 1, 2));
      tbl.push_back(V(0, 0, 0,     0,  0, 0, 0, 0,            0, 0, 0,            0,  1, 1, 0, 0, 0, 0,            0,            0,   0,     0, 0, 0));

      // clock/reset
      drive(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      tick();

      for (int k = 0; k < tbl.size(); k++) run_vec(k, tbl[k]);

      // Starved read with writebacks held continuously, measured by cycle count.
      exp_q.push_back({4'hB, 32'h99999999, 32'h0000ABCD});
      dec_valid = 1'b1; dec_op = 8'h66; dec_rd = 4'hB; dec_rm = 4'd2; dec_rn = 4'd1;
      dec_use_imm = 1'b1; dec_imm = 32'h0000ABCD;
      wb_valid = 1'b1; wb_adr = 4'd5; wb_data = 32'h55555555; ex_ready = 1'b0;
      #2;
      chk("seq_accept_ready", 32'(dec_ready), 32'd1);
      tick();
      dec_valid = 1'b0;
      lat = 1;
      while (ex_valid !== 1'b1 && lat < 12) begin
         tick();
         lat++;
      end
      chk("seq_latency", 32'(lat), 32'd5);
      ex_ready = 1'b1;
      #2;
      if (ex_valid === 1'b1 && exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         chk("seq_bundle", {ex_rd, ex_a[27:0]}, {exp_b[67:64], exp_b[59:32]});
         chk("seq_ex_b", ex_b, exp_b[31:0]);
      end else begin
         chk("seq_handshake_seen", 32'(ex_valid), 32'd1);
      end
      tick();
      ex_ready = 1'b0;
      wb_valid = 1'b0;
      #2;
      chk("seq_idle_ex_valid", 32'(ex_valid), 32'd0);
      chk("seq_idle_dec_ready", 32'(dec_ready), 32'd1);
      chk("seq_r5_written", mem[5], 32'h55555555);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
